// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor built from a table of 2-bit saturating counters.
// The fetch PC indexes the table either directly (bimodal, MODE=0) or XORed
// with a non-speculative global history register (gshare, MODE=1). The
// prediction is a pure combinational read. Resolved branches come back with
// the index they were predicted with, and they update the counter, the history
// and the accuracy statistics on the next rising edge.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   pcF             fetch-stage PC
//   pred_takeF      prediction for pcF (bit 1 of the selected counter)
//   pred_idxF       table index used for pcF; the pipeline carries it with the branch
//   upd_en          a branch resolved this cycle
//   upd_idx         pred_idxF carried with the resolving branch
//   upd_taken       actual outcome of the resolving branch
//   upd_mispredict  the carried prediction differed from the outcome
//   ghr             current global history (newest outcome in bit 0)
//   branch_cnt      resolved branches, saturating
//   mispred_cnt     mispredicted branches, saturating
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         IDX_W    = 6,
    parameter int         GHR_W    = 6,
    parameter int         MODE     = 0,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pcF,
    output logic              pred_takeF,
    output logic [IDX_W-1:0]  pred_idxF,
    input  logic              upd_en,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [GHR_W-1:0]  ghr,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]        cnt_q [ENTRIES];
    logic [1:0]        cnt_cur;
    logic [1:0]        cnt_d;
    logic [GHR_W-1:0]  ghr_q;
    logic [GHR_W-1:0]  ghr_d;
    logic [STAT_W-1:0] branch_cnt_q;
    logic [STAT_W-1:0] branch_cnt_d;
    logic [STAT_W-1:0] mispred_cnt_q;
    logic [STAT_W-1:0] mispred_cnt_d;
    logic [IDX_W-1:0]  pc_idx;

    // Word-aligned PC bits select the entry; the rest of the PC is ignored.
    assign pc_idx = pcF[IDX_W+1:2];

    logic unused_pc;
    assign unused_pc = ^{pcF[31:IDX_W+2], pcF[1:0]};

    // ---------------------------------------------------------------- lookup
    generate
        if (MODE == 1) begin : g_gshare
            // History is shorter than or equal to the index; zero-extend it.
            assign pred_idxF = pc_idx ^ IDX_W'(ghr_q);
        end else begin : g_bimodal
            assign pred_idxF = pc_idx;
        end
    endgenerate

    // The table is read from the registered state, so an update in the same
    // cycle is only seen from the following cycle (read-before-write). While
    // reset is held the table may not yet be initialised, so the reset
    // prediction is forced.
    assign pred_takeF = rst ? CNT_INIT[1] : cnt_q[pred_idxF][1];

    // ---------------------------------------------------------------- update
    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        cnt_cur       = cnt_q[upd_idx];
        cnt_d         = cnt_cur;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (upd_taken) begin
            if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
        end

        // Statistics stick at all-ones instead of wrapping.
        if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_W'(1);
        if (upd_mispredict && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end

    generate
        if (GHR_W == 1) begin : g_ghr1
            assign ghr_d = upd_taken;
        end else begin : g_ghrn
            assign ghr_d = {ghr_q[GHR_W-2:0], upd_taken};
        end
    endgenerate

    // NOTE: the counter table is a register array, not a RAM macro, because
    // every entry must return to CNT_INIT in a single reset cycle; it is
    // therefore reset entry by entry here.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_en) begin
            cnt_q[upd_idx] <= cnt_d;
            ghr_q          <= ghr_d;
            branch_cnt_q   <= branch_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
        end
    end

    assign ghr         = ghr_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor. Three instances share clock, reset, PC
// and update payload, each with its own update enable:
//   a: bimodal, IDX_W=6, GHR_W=6, STAT_W=32
//   b: gshare,  IDX_W=4, GHR_W=4, STAT_W=32
//   c: bimodal, IDX_W=6, GHR_W=6, STAT_W=4
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic        upd_mis;
    logic        en_a, en_b, en_c;

    logic        pred_a, pred_b, pred_c;
    logic [5:0]  idx_a, idx_c;
    logic [3:0]  idx_b;
    logic [5:0]  ghr_a, ghr_c;
    logic [3:0]  ghr_b;
    logic [31:0] bc_a, mc_a, bc_b, mc_b;
    logic [3:0]  bc_c, mc_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] sat_taken;
    logic [7:0] sat_pred;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(6), .GHR_W(6), .MODE(0), .CNT_INIT(2'b01), .STAT_W(32)) u_a (
        .clk(clk), .rst(rst), .pcF(pc), .pred_takeF(pred_a), .pred_idxF(idx_a),
        .upd_en(en_a), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mis),
        .ghr(ghr_a), .branch_cnt(bc_a), .mispred_cnt(mc_a)
    );

    branch_predictor #(.IDX_W(4), .GHR_W(4), .MODE(1), .CNT_INIT(2'b01), .STAT_W(32)) u_b (
        .clk(clk), .rst(rst), .pcF(pc), .pred_takeF(pred_b), .pred_idxF(idx_b),
        .upd_en(en_b), .upd_idx(upd_idx[3:0]), .upd_taken(upd_taken), .upd_mispredict(upd_mis),
        .ghr(ghr_b), .branch_cnt(bc_b), .mispred_cnt(mc_b)
    );

    branch_predictor #(.IDX_W(6), .GHR_W(6), .MODE(0), .CNT_INIT(2'b01), .STAT_W(4)) u_c (
        .clk(clk), .rst(rst), .pcF(pc), .pred_takeF(pred_c), .pred_idxF(idx_c),
        .upd_en(en_c), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispredict(upd_mis),
        .ghr(ghr_c), .branch_cnt(bc_c), .mispred_cnt(mc_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One resolved branch on the selected instances ({c,b,a}); returns 1 ns
    // after the edge with the enables dropped.
    task automatic upd(input logic [2:0] which, input logic [5:0] idx,
                       input logic taken, input logic mis);
        {en_c, en_b, en_a} = which;
        upd_idx   = idx;
        upd_taken = taken;
        upd_mis   = mis;
        @(posedge clk); #1;
        {en_c, en_b, en_a} = 3'b000;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h14; upd_idx = '0; upd_taken = 1'b0; upd_mis = 1'b0;
        {en_c, en_b, en_a} = 3'b000;

        // ---------------------------------------------------- reset defaults
        @(posedge clk); #1;
        check("pred_during_rst", pred_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            pc = 32'(i * 4);
            #1;
            check("sweep_pred", pred_a, 0);
            check("sweep_idx", idx_a, 32'(i));
        end
        @(posedge clk); #1;
        check("rst_ghr", ghr_a, 0);
        check("rst_branch_cnt", bc_a, 0);
        check("rst_mispred_cnt", mc_a, 0);
        pc = 32'hFFFF_FF14;
        #1;
        check("idx_high_pc_bits", idx_a, 5);

        // --------------------------------------- same-cycle read-before-write
        pc = 32'h14;
        en_a = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1; upd_mis = 1'b0;
        #1;
        check("bypass_same_cycle", pred_a, 0);
        @(posedge clk); #1;
        en_a = 1'b0;
        check("bypass_next_cycle", pred_a, 1);

        // ------------------------------------------------ saturation, idx 5
        sat_taken = 8'b1100_0011;
        sat_pred  = 8'b1110_0001;
        for (int i = 0; i < 8; i++) begin
            upd(3'b001, 6'd5, sat_taken[7-i], 1'b0);
            check("sat_pred", pred_a, 32'(sat_pred[7-i]));
        end
        check("sat_ghr", ghr_a, 6'b000011);
        check("sat_branch_cnt", bc_a, 9);
        check("sat_mispred_cnt", mc_a, 0);

        // ------------------------------------------------ statistics, idx 10
        for (int i = 0; i < 10; i++)
            upd(3'b001, 6'd10, 1'b1, (i == 1) || (i == 4) || (i == 7));
        upd_taken = 1'b0;
        upd_mis   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        upd_mis = 1'b0;
        check("stat_branch_cnt", bc_a, 19);
        check("stat_mispred_cnt", mc_a, 3);
        check("stat_ghr_idle", ghr_a, 6'b111111);
        pc = 32'h28;
        #1;
        check("idx10_pred", pred_a, 1);
        check("idx10_mode0_idx", idx_a, 10);
        pc = 32'h14;
        #1;
        check("idx5_untouched", pred_a, 1);

        // ------------------------------------------------------------ gshare
        check("gs_ghr_init", ghr_b, 0);
        pc = 32'h08;
        #1;
        check("gs_idx_init", idx_b, 4'b0010);
        upd(3'b010, 6'd0, 1'b1, 1'b0);
        upd(3'b010, 6'd0, 1'b0, 1'b0);
        upd(3'b010, 6'd0, 1'b1, 1'b0);
        check("gs_ghr_3", ghr_b, 4'b0101);
        en_b = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1; upd_mis = 1'b1;
        #1;
        check("gs_idx_pre_update", idx_b, 4'b0111);
        @(posedge clk); #1;
        en_b = 1'b0;
        upd_mis = 1'b0;
        check("gs_ghr_1011", ghr_b, 4'b1011);
        check("gs_idx_1001", idx_b, 4'b1001);
        check("gs_pred_idx9", pred_b, 0);
        pc = 32'h2C;
        #1;
        check("gs_idx_zero", idx_b, 0);
        check("gs_pred_idx0", pred_b, 1);
        check("gs_branch_cnt", bc_b, 4);
        check("gs_mispred_cnt", mc_b, 1);
        check("a_ghr_unaffected", ghr_a, 6'b111111);

        // ------------------------------------------ narrow stats saturation
        for (int i = 0; i < 15; i++) upd(3'b100, 6'd0, 1'b0, 1'b1);
        check("c_branch_15", bc_c, 15);
        check("c_mispred_15", mc_c, 15);
        for (int i = 0; i < 5; i++) upd(3'b100, 6'd0, 1'b0, 1'b1);
        check("c_branch_sat", bc_c, 15);
        check("c_mispred_sat", mc_c, 15);
        pc = 32'h00;
        #1;
        check("c_pred_floor", pred_c, 0);

        // -------------------------------------------- reset mid-stream, idx 2
        upd(3'b001, 6'd2, 1'b1, 1'b0);
        upd(3'b001, 6'd2, 1'b1, 1'b0);
        pc = 32'h08;
        #1;
        check("idx2_strong", pred_a, 1);
        en_a = 1'b1; upd_idx = 6'd2; upd_taken = 1'b1; upd_mis = 1'b1;
        rst  = 1'b1;
        #1;
        check("pred_forced_in_rst", pred_a, 0);
        @(posedge clk); #1;
        rst = 1'b0; en_a = 1'b0; upd_mis = 1'b0;
        check("mid_rst_ghr", ghr_a, 0);
        check("mid_rst_branch_cnt", bc_a, 0);
        check("mid_rst_mispred_cnt", mc_a, 0);
        check("mid_rst_pred", pred_a, 0);
        upd(3'b001, 6'd2, 1'b1, 1'b0);
        check("post_rst_cnt01_to_10", pred_a, 1);
        check("post_rst_ghr", ghr_a, 1);
        check("post_rst_branch_cnt", bc_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
